// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: loads a program into instruction
// memory, then sequences PC through RUN until it halts.
`timescale 1ns/1ps

module fetch_ctrl #(
    parameter int SIZE = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        im_we,
    output logic [31:0] im_waddr,
    output logic [31:0] im_wdata,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    // First byte address past the end of instruction memory
    localparam logic [31:0] PC_LIMIT = 32'(SIZE * 4);
    localparam logic [31:0] LAST_IDX = 32'(SIZE - 1);

    state_t      st_q;
    state_t      st_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [31:0] pc_nxt;

    // State, PC and load counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q  <= LOAD;
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Candidate next PC: jump beats branch beats sequential; targets word-aligned
    always_comb begin
        if (jump) begin
            pc_nxt = jump_target & ~32'h3;
        end else if (branch_taken) begin
            pc_nxt = branch_target & ~32'h3;
        end else begin
            pc_nxt = pc_q + 32'd4;
        end
    end

    // Next-state and output decode
    always_comb begin
        st_d       = st_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        load_ready = 1'b0;
        im_we      = 1'b0;
        im_waddr   = cnt_q << 2;
        im_wdata   = load_data;
        if_valid   = 1'b0;
        if_instr   = '0;
        if_pc      = pc_q;
        halted     = 1'b0;
        case (st_q)
            LOAD: begin
                load_ready = 1'b1;
                im_we      = load_valid;
                if (load_valid) begin
                    cnt_d = cnt_q + 32'd1;
                    if (load_last || cnt_q == LAST_IDX) begin
                        st_d = RUN;
                        pc_d = '0;
                    end
                end
            end
            RUN: begin
                if_valid = 1'b1;
                if_instr = instruction;
                // A halt request wins; a stall discards any redirect
                if (halt_req) begin
                    st_d = HALT;
                end else if (!stall) begin
                    if (pc_nxt >= PC_LIMIT) begin
                        st_d = HALT;
                    end else begin
                        pc_d = pc_nxt;
                    end
                end
            end
            default: begin
                // HALT, and the unused 11 encoding treated as HALT
                halted = 1'b1;
                st_d   = HALT;
            end
        endcase
    end

    assign PC    = pc_q;
    assign state = st_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus
// randomized load/run episodes against a behavioural model.
`timescale 1ns/1ps

module tb_fetch_ctrl;

    localparam int SZ = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        im_we;
    logic [31:0] im_waddr;
    logic [31:0] im_wdata;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic [1:0]  state;

    always #5 clk = ~clk;

    fetch_ctrl #(.SIZE(SZ)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .PC(PC), .instruction(instruction), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt_req(halt_req),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .state(state)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: mode 0=loading, 1=running, 2=halted
    int          m_mode;
    logic [31:0] m_pc;
    int          m_words;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_words = 0;
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), 32'(m_mode));
        chk("PC", PC, m_pc);
        chk("load_ready", 32'(load_ready), 32'(m_mode == 0));
        chk("im_we", 32'(im_we), 32'(m_mode == 0 && load_valid));
        if (m_mode == 0 && load_valid) begin
            chk("im_waddr", im_waddr, 32'(m_words * 4));
            chk("im_wdata", im_wdata, load_data);
        end
        chk("if_valid", 32'(if_valid), 32'(m_mode == 1));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        if (m_mode == 1) begin
            chk("if_pc", if_pc, m_pc);
            chk("if_instr", if_instr, instruction);
        end
    endtask

    task automatic model_edge();
        logic [31:0] target;
        if (m_mode == 0) begin
            if (load_valid) begin
                if (load_last || m_words == SZ - 1) begin
                    m_mode = 1;
                    m_pc   = 0;
                end
                m_words++;
            end
        end else if (m_mode == 1) begin
            if (halt_req) begin
                m_mode = 2;
            end else if (!stall) begin
                if (jump) target = {jump_target[31:2], 2'b00};
                else if (branch_taken) target = {branch_target[31:2], 2'b00};
                else target = m_pc + 32'd4;
                if (target >= 32'(SZ * 4)) m_mode = 2;
                else m_pc = target;
            end
        end
    endtask

    // One clock cycle with the inputs currently applied
    task automatic cyc();
        instruction = $urandom;
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid    = 0;
        load_data     = 0;
        load_last     = 0;
        stall         = 0;
        branch_taken  = 0;
        branch_target = 0;
        jump          = 0;
        jump_target   = 0;
        halt_req      = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        idle_inputs();
        load_valid = 1;
        load_data  = d;
        load_last  = last;
        cyc();
    endtask

    task automatic run(input logic s, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt, input logic h);
        idle_inputs();
        stall         = s;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        halt_req      = h;
        cyc();
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 19) == 0) return $urandom;
        return 32'($urandom_range(0, SZ * 4 + 64));
    endfunction

    initial begin
        int n;
        idle_inputs();
        instruction = 0;
        reset = 1;
        #2;
        do_reset();

        // Three-word program, last flag on the third word
        load_word(32'h20080020, 0);
        load_word(32'h20090037, 0);
        load_word(32'h01098024, 1);
        idle_inputs();
        chk("load3_state", 32'(state), 32'h1);
        chk("load3_pc", PC, 32'h0);

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", PC, 32'(i * 4));
            run(0, 0, 0, 0, 0, 0);
        end

        // Branch alignment and jump-over-branch priority
        run(0, 1, 32'h20, 0, 0, 0);
        chk("pre_branch_pc", PC, 32'h20);
        run(0, 0, 0, 1, 32'h3A, 0);
        chk("branch_align_pc", PC, 32'h38);
        run(0, 1, 32'h20, 0, 0, 0);
        run(0, 1, 32'h38, 1, 32'h10, 0);
        chk("jump_prio_pc", PC, 32'h38);

        // Redirect discarded under stall, taken once stall drops
        run(1, 1, 32'h80, 0, 0, 0);
        run(1, 1, 32'h80, 0, 0, 0);
        chk("stall_hold_pc", PC, 32'h38);
        run(0, 1, 32'h80, 0, 0, 0);
        chk("stall_release_pc", PC, 32'h80);

        // Running off the end of memory halts at the last word
        run(0, 1, 32'h18C, 0, 0, 0);
        chk("end_pc", PC, 32'h18C);
        run(0, 0, 0, 0, 0, 0);
        chk("oor_state", 32'(state), 32'h2);
        chk("oor_halted", 32'(halted), 32'h1);
        chk("oor_if_valid", 32'(if_valid), 32'h0);
        chk("oor_pc", PC, 32'h18C);
        for (int i = 0; i < 4; i++) begin
            run(0, 1, 32'h10, 1, 32'h20, 0);
            load_valid = 1;
            cyc();
        end

        // Full-depth load without a last flag
        do_reset();
        for (int i = 0; i < SZ; i++) begin
            if (i % 17 == 5) begin
                idle_inputs();
                cyc();
            end
            load_word($urandom, 0);
        end
        idle_inputs();
        chk("full_load_state", 32'(state), 32'h1);

        // Halt request beats stall
        run(1, 0, 0, 0, 0, 1);
        chk("halt_req_state", 32'(state), 32'h2);
        run(0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        do_reset();
        load_word(32'h1, 1);
        run(0, 1, 32'h40, 0, 0, 0);
        chk("pre_rst_pc", PC, 32'h40);
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("async_state", 32'(state), 32'h0);
        chk("async_pc", PC, 32'h0);
        chk("async_halted", 32'(halted), 32'h0);
        chk("async_ready", 32'(load_ready), 32'h1);
        @(posedge clk);
        #1;
        reset = 0;
        idle_inputs();
        load_valid = 1;
        load_data  = 32'hCAFE0001;
        #1;
        chk("reload_waddr", im_waddr, 32'h0);
        chk("reload_we", 32'(im_we), 32'h1);
        cyc();

        // Randomized load/run episodes
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            n = $urandom_range(1, SZ);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle_inputs();
                    cyc();
                end
                load_word($urandom,
                          (i == n - 1) && (n < SZ || $urandom_range(0, 1) == 1));
            end
            for (int k = 0; k < 150; k++) begin
                idle_inputs();
                stall         = ($urandom_range(0, 3) == 0);
                jump          = ($urandom_range(0, 5) == 0);
                jump_target   = rand_target();
                branch_taken  = ($urandom_range(0, 4) == 0);
                branch_target = rand_target();
                halt_req      = ($urandom_range(0, 99) == 0);
                load_valid    = ($urandom_range(0, 1) == 1);
                load_data     = $urandom;
                load_last     = ($urandom_range(0, 1) == 1);
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter SIZE, default 100, instruction-memory depth in 32-bit words.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 load_valid  in  1  host offers a program word.
REQ-005 load_data  in  32  program word.
REQ-006 load_last  in  1  qualifies load_valid; marks final program word.
REQ-007 load_ready  out  1  controller accepts a program word this cycle.
REQ-008 im_we  out  1  instruction-memory write enable.
REQ-009 im_waddr  out  32  instruction-memory byte write address.
REQ-010 im_wdata  out  32  instruction-memory write data.
REQ-011 PC  out  32  fetch byte address driven to instruction memory.
REQ-012 instruction  in  32  word returned by instruction memory for PC (combinational).
REQ-013 stall  in  1  hold PC this cycle.
REQ-014 branch_taken  in  1  redirect to branch_target.
REQ-015 branch_target  in  32  branch byte address.
REQ-016 jump  in  1  redirect to jump_target.
REQ-017 jump_target  in  32  jump byte address.
REQ-018 halt_req  in  1  request to stop fetching.
REQ-019 if_valid  out  1  if_instr/if_pc valid for decode.
REQ-020 if_instr  out  32  fetched instruction.
REQ-021 if_pc  out  32  address of if_instr.
REQ-022 halted  out  1  controller in HALT.
REQ-023 state  out  2  encoded state: LOAD=00, RUN=01, HALT=10.

Function
REQ-024 FSM SHALL have states LOAD, RUN, HALT; encoding 11 unreachable, SHALL decode as HALT.
REQ-025 LOAD: load_ready=1; each cycle with load_valid=1 writes one word: im_we=load_valid (combinational), im_wdata=load_data, im_waddr=load_count*4.
REQ-026 load_count SHALL increment per accepted word, starting at 0.
REQ-027 LOAD->RUN on accepted word with load_last=1, or on accepted word when load_count=SIZE-1; load_count SHALL NOT wrap.
REQ-028 Entering RUN: PC=0 on the transition edge.
REQ-029 Outside LOAD: load_ready=0, im_we=0; load_valid ignored.
REQ-030 RUN: if_valid=1, if_instr=instruction, if_pc=PC (combinational pass-through).
REQ-031 RUN next-PC priority per edge: halt_req > stall (hold) > jump (jump_target) > branch_taken (branch_target) > PC+4.
REQ-032 Redirect targets SHALL have bits [1:0] forced to 00 before loading PC.
REQ-033 RUN->HALT when halt_req=1, or when the selected next PC >= SIZE*4 (no out-of-range fetch); PC keeps last in-range value.
REQ-034 Redirect asserted while stall=1 SHALL be discarded; upstream holds it until stall drops.
REQ-035 HALT: if_valid=0, halted=1, PC frozen; exit only via reset.
REQ-036 PC arithmetic 32-bit unsigned, modulo 2^32; compare against SIZE*4 unsigned.

Reset
REQ-037 reset=1 SHALL immediately force: state=LOAD, load_count=0, PC=0, halted=0, if_valid=0, load_ready=1 (combinational from state), im_we=load_valid.
REQ-038 Reset mid-LOAD or mid-RUN SHALL abandon the operation; reload starts at word 0.

Verification
REQ-039 Load 3 words 0x20080020, 0x20090037, 0x01098024 (last on third) -> im_we 3 cycles at addresses 0,4,8, state=01 next cycle, PC=0.
REQ-040 RUN, no stall/redirect, 4 cycles -> PC 0,4,8,12, if_valid=1, if_pc=PC.
REQ-041 At PC=0x20, branch_taken=1, branch_target=0x3A -> next PC=0x38; same cycle jump=1, jump_target=0x38, branch_target=0x10 -> PC=0x38.
REQ-042 stall=1 with jump=1 for 2 cycles -> PC unchanged; stall=0 with jump held -> PC=jump_target.
REQ-043 SIZE=100, PC=0x18C, no redirect -> state=10, halted=1, if_valid=0, PC stays 0x18C; 100 words loaded without load_last -> RUN after word 99.
REQ-044 reset pulsed mid-RUN at PC=0x40 -> state=00, PC=0 asynchronously; next load_valid writes address 0.
